// File: rtl/spi_master_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_sequencer
// Purpose  : SPI mode-0, 8-bit master that shares one slave between two
//            requesters under round-robin arbitration. It drives ss/sclk/mosi,
//            samples miso, and returns the received byte together with a
//            one-cycle done pulse to the requester that was served.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            req[1:0]       - level requests, held until the matching done
//            tx_data0/1     - byte per requester, captured at grant
//            grant[1:0]     - one-hot, high for the whole served transaction
//            done[1:0]      - one-cycle pulse at transaction end
//            rx_data[7:0]   - byte received on miso, valid from done
//            busy           - high whenever the sequencer is not idle
//            ss, sclk, mosi - SPI outputs (ss active low, sclk idles low)
//            miso           - SPI input, slave transmits LSB first
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_sequencer #(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [7:0] tx_data0,
    input  logic [7:0] tx_data1,
    output logic [1:0] grant,
    output logic [1:0] done,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       ss,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    // One counter serves both the sclk half-periods and the inter-frame gap.
    localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] c_DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST = CNT_W'(GAP_CYC - 1);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LEAD = 3'd1;
    localparam logic [2:0] c_HIGH = 3'd2;
    localparam logic [2:0] c_LOW  = 3'd3;
    localparam logic [2:0] c_GAP  = 3'd4;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_tx;
    logic [7:0]       r_rx;
    logic             r_last;
    logic             r_ss;
    logic             r_sclk;
    logic             r_mosi;
    logic [1:0]       r_grant;
    logic [1:0]       r_done;
    logic [7:0]       r_rx_data;
    logic             r_busy;

    // ------------------------------------------------------------------------
    // Combinational next values
    // ------------------------------------------------------------------------
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       w_tx_nxt;
    logic [7:0]       w_rx_nxt;
    logic             w_last_nxt;
    logic             w_ss_nxt;
    logic             w_sclk_nxt;
    logic             w_mosi_nxt;
    logic [1:0]       w_grant_nxt;
    logic [1:0]       w_done_nxt;
    logic [7:0]       w_rx_data_nxt;
    logic             w_busy_nxt;

    logic             w_phase_end;
    logic             w_win_valid;
    logic             w_win;
    logic [7:0]       w_tx_sel;
    logic [2:0]       w_tx_idx;

    assign w_phase_end = (r_state == c_GAP) ? (r_cnt == c_GAP_LAST)
                                            : (r_cnt == c_DIV_LAST);

    // Winner index: a lone request wins outright; on a tie the requester
    // that was not served last time wins.
    assign w_win_valid = |req;
    assign w_win       = (req == 2'b11) ? ~r_last : req[1];
    assign w_tx_sel    = w_win ? tx_data1 : tx_data0;

    // Next mosi bit after falling edge k is tx[6-k]; only used while k<7.
    assign w_tx_idx    = 3'd6 - r_bit;

    // ------------------------------------------------------------------------
    // Process 1: state and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_bit     <= 3'd0;
            r_tx      <= 8'h00;
            r_rx      <= 8'h00;
            r_last    <= 1'b1;
            r_ss      <= 1'b1;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_grant   <= 2'b00;
            r_done    <= 2'b00;
            r_rx_data <= 8'h00;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_tx      <= w_tx_nxt;
            r_rx      <= w_rx_nxt;
            r_last    <= w_last_nxt;
            r_ss      <= w_ss_nxt;
            r_sclk    <= w_sclk_nxt;
            r_mosi    <= w_mosi_nxt;
            r_grant   <= w_grant_nxt;
            r_done    <= w_done_nxt;
            r_rx_data <= w_rx_data_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (w_win_valid) w_state_nxt = c_LEAD;
            c_LEAD: if (w_phase_end) w_state_nxt = c_HIGH;
            c_HIGH: if (w_phase_end) w_state_nxt = c_LOW;
            c_LOW:  if (w_phase_end) w_state_nxt = (r_bit == 3'd7) ? c_GAP : c_HIGH;
            c_GAP:  if (w_phase_end) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Process 3: next values of the registered outputs and datapath
    // ------------------------------------------------------------------------
    always_comb begin
        w_cnt_nxt     = (r_state == c_IDLE || w_phase_end) ? '0 : r_cnt + CNT_W'(1);
        w_bit_nxt     = r_bit;
        w_tx_nxt      = r_tx;
        w_rx_nxt      = r_rx;
        w_last_nxt    = r_last;
        w_ss_nxt      = r_ss;
        w_sclk_nxt    = r_sclk;
        w_mosi_nxt    = r_mosi;
        w_grant_nxt   = r_grant;
        w_done_nxt    = 2'b00;
        w_rx_data_nxt = r_rx_data;
        w_busy_nxt    = (w_state_nxt != c_IDLE);

        case (r_state)
            c_IDLE: begin
                w_ss_nxt   = 1'b1;
                w_sclk_nxt = 1'b0;
                if (w_win_valid) begin
                    w_tx_nxt    = w_tx_sel;
                    w_grant_nxt = w_win ? 2'b10 : 2'b01;
                    w_last_nxt  = w_win;
                    w_mosi_nxt  = w_tx_sel[7];
                    w_ss_nxt    = 1'b0;
                    w_bit_nxt   = 3'd0;
                    w_rx_nxt    = 8'h00;
                end
            end
            c_LEAD: begin
                if (w_phase_end) w_sclk_nxt = 1'b1;
            end
            c_HIGH: begin
                // mosi moves together with the falling edge so it is stable
                // for a full half-period before the next rising edge.
                if (w_phase_end) begin
                    w_sclk_nxt = 1'b0;
                    if (r_bit != 3'd7) w_mosi_nxt = r_tx[w_tx_idx];
                end
            end
            c_LOW: begin
                if (w_phase_end) begin
                    w_rx_nxt[r_bit] = miso;
                    if (r_bit == 3'd7) begin
                        w_ss_nxt      = 1'b1;
                        w_mosi_nxt    = 1'b0;
                        w_grant_nxt   = 2'b00;
                        w_done_nxt    = r_grant;
                        w_rx_data_nxt = {miso, r_rx[6:0]};
                    end else begin
                        w_bit_nxt  = r_bit + 3'd1;
                        w_sclk_nxt = 1'b1;
                    end
                end
            end
            c_GAP: begin
                w_ss_nxt = 1'b1;
            end
            default: begin
                w_ss_nxt   = 1'b1;
                w_sclk_nxt = 1'b0;
            end
        endcase
    end

    assign grant   = r_grant;
    assign done    = r_done;
    assign rx_data = r_rx_data;
    assign busy    = r_busy;
    assign ss      = r_ss;
    assign sclk    = r_sclk;
    assign mosi    = r_mosi;

endmodule
`default_nettype wire

// File: doc/spi_master_sequencer.md
# spi_master_sequencer

- Sequences SPI transactions toward the SPI slave block (mode 0, 8-bit) and shares that bus between two requesters under round-robin arbitration.
- Drives `ss`, `sclk` and `mosi`, samples `miso`, and returns the received byte with a one-cycle completion pulse.
- Sits between the requester logic and the slave's `ss_in`/`sclk_in`/`mosi_in`/`miso` pins. It replaces free-running stimulus with a rule-abiding master.

## Interface
Parameters:
- `CLK_DIV`, default 4: clk cycles per sclk half-period; legal minimum 4, which covers the slave's edge-detect and miso latency.
- `GAP_CYC`, default 4: clk cycles `ss` stays high after each transaction; legal minimum 4, which covers the slave's 2-stage ss delay and flag clear.

Ports:
- `clk` in 1: the single clock; all logic on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 2: request per requester; level, held until that requester's `done`.
- `tx_data0` in 8: byte for requester 0; sampled at grant.
- `tx_data1` in 8: byte for requester 1; sampled at grant.
- `grant` out 2: one-hot, high for the whole transaction of the served requester.
- `done` out 2: one-cycle pulse to the served requester at transaction end.
- `rx_data` out 8: byte received on `miso`; valid from the `done` pulse until the next `done`.
- `busy` out 1: high in every state except IDLE.
- `ss` out 1: slave select, active low.
- `sclk` out 1: serial clock, idle low.
- `mosi` out 1: master out, MSB first.
- `miso` in 1: slave out, LSB first.

## Operation
- All outputs are registered.
- Reset values: `ss`=1, `sclk`=0, `mosi`=0, `grant`=00, `done`=00, `rx_data`=0x00, `busy`=0, state IDLE, round-robin pointer `last`=1, so requester 0 wins the first tie.
- Internal counters: half-period counter 0..CLK_DIV-1; bit index k 0..7 (3 bits, no wrap beyond 7); 8-bit tx shift register; 8-bit rx register.

FSM:
- IDLE
  - `ss`=1, `sclk`=0.
  - If `req`≠00, pick the winner:
    - only one set: that one;
    - both set: the one ≠ `last`.
  - On winning, latch its tx_data, set `grant`, update `last`, set `mosi`=tx[7], set `ss`=0, k=0, and go to LEAD.
- LEAD
  - `sclk`=0 for CLK_DIV cycles, then go to HIGH.
- HIGH(k)
  - `sclk`=1 for CLK_DIV cycles.
  - The slave samples `mosi` on the rising edge.
  - Then go to LOW(k) with `sclk`=0.
- LOW(k)
  - On entry, if k<7, `mosi`=tx[6-k].
  - On the last cycle of the phase, `rx[k]`←`miso`.
  - Then:
    - if k<7: k←k+1, go to HIGH(k+1);
    - if k=7: go to GAP with `ss`=1, `mosi`=0, `grant`=00, `done`[winner]=1, `rx_data`←assembled byte.
- GAP
  - `ss`=1 for GAP_CYC cycles, then go to IDLE.

Rules:
- Bit order: `mosi` is sent MSB first. `rx_data[i]` holds the bit sampled after falling edge i, matching the slave's LSB-first transmit.
- Dropping `req` mid-transaction is ignored: the transaction completes and `done` still pulses.
- A requester whose `req` is still high after its `done` is re-arbitrated in IDLE like any other request.
- `tx_data` changes after grant have no effect.
- Asynchronous `rst` mid-transaction immediately forces all reset values, including `ss`=1. The partial byte is discarded and no `done` is produced.

## Timing
- A `req` seen in IDLE at edge t gives `grant`, `ss`=0 and `mosi`=tx[7] visible after edge t+1.
- `ss` is low for exactly 17·CLK_DIV cycles (68 at default).
- 8 rising and 8 falling sclk edges per transaction. The first rising edge comes CLK_DIV cycles after `ss` falls.
- `done` pulses for 1 cycle on the same cycle `ss` returns high.
- Back-to-back period per transaction: 1 + 17·CLK_DIV + GAP_CYC cycles (73 at default). IDLE always lasts at least 1 cycle.
- `mosi` only changes while `sclk`=0, CLK_DIV cycles before each rising edge.

## Test plan
- Single request: req=01, tx_data0=0xA5, behavioral slave returns 0x3C → `mosi` at the 8 rising edges is 1,0,1,0,0,1,0,1. `ss` is low for 68 cycles. `done`=01 for one cycle. `rx_data`=0x3C.
- Simultaneous first requests after reset: req=11 held → grant order 01, then 10. Each gets its own byte: tx0=0x0F, tx1=0xF0 are seen on `mosi` in that order. `ss` high between them for exactly 4 cycles.
- Fairness: req=11 held for 6 transactions → grant alternates 01,10,01,10,01,10. Period is 73 cycles.
- Request drop: req=10 asserted, then deasserted after 20 cycles → the transaction completes, `done`=10 still pulses, no second transaction starts.
- Reset mid-op: assert `rst` at bit k=3 → in the same cycle `ss`=1, `sclk`=0, `grant`=00, `busy`=0, `rx_data`=0x00. After release with req=01 held → a fresh full transaction, and the slave's `byte_transfered` restarts from 0.
- CLK_DIV=6, GAP_CYC=5: tx=0x81 → sclk half-periods are 6 cycles, `ss` low for 102 cycles, period 108 cycles. Received byte is correct against the slave.
